// File: rtl/proc_ctrl.sv
// Multi-cycle control unit: latches an instruction from din and sequences
// mv / mvi / add / sub over one to three execute cycles.
module proc_ctrl #(
  parameter int DW   = 16,
  parameter int NREG = 16
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            run,
  input  logic [DW-1:0]   din,
  output logic            ir_load,
  output logic [NREG-1:0] rin,
  output logic [NREG-1:0] rout,
  output logic            ain,
  output logic            gin,
  output logic            addsub,
  output logic            gout,
  output logic            dinout,
  output logic            done,
  output logic            busy
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  state_t      state;
  state_t      state_next;
  logic [10:0] ir;
  logic [2:0]  opcode;
  logic [3:0]  rx;
  logic [3:0]  ry;
  logic        din_unused;

  // Only din[10:0] carries the instruction; upper bits belong to the datapath.
  assign din_unused = ^din[DW-1:11];

  assign opcode = ir[10:8];
  assign rx     = ir[7:4];
  assign ry     = ir[3:0];

  function automatic logic [NREG-1:0] onehot(input logic [3:0] f);
    logic [NREG-1:0] one;
    one = NREG'(1);
    return one << f;
  endfunction

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= T0;
      ir    <= '0;
    end else begin
      state <= state_next;
      if (state == T0 && run) begin
        ir <= din[10:0];
      end
    end
  end

  always_comb begin
    state_next = state;
    ir_load    = 1'b0;
    rin        = '0;
    rout       = '0;
    ain        = 1'b0;
    gin        = 1'b0;
    addsub     = 1'b0;
    gout       = 1'b0;
    dinout     = 1'b0;
    done       = 1'b0;
    busy       = (state != T0);

    case (state)
      T0: begin
        ir_load = run;
        if (run) begin
          state_next = T1;
        end
      end
      T1: begin
        case (opcode)
          OP_MV: begin
            rout       = onehot(ry);
            rin        = onehot(rx);
            done       = 1'b1;
            state_next = T0;
          end
          OP_MVI: begin
            dinout     = 1'b1;
            rin        = onehot(rx);
            done       = 1'b1;
            state_next = T0;
          end
          OP_ADD, OP_SUB: begin
            rout       = onehot(rx);
            ain        = 1'b1;
            state_next = T2;
          end
          default: begin
            done       = 1'b1;
            state_next = T0;
          end
        endcase
      end
      T2: begin
        rout       = onehot(ry);
        gin        = 1'b1;
        addsub     = (opcode == OP_SUB);
        state_next = T3;
      end
      T3: begin
        gout       = 1'b1;
        rin        = onehot(rx);
        done       = 1'b1;
        state_next = T0;
      end
      default: state_next = T0;
    endcase

    // Outputs are held quiet for the whole time reset is asserted.
    if (!resetn) begin
      ir_load = 1'b0;
      rin     = '0;
      rout    = '0;
      ain     = 1'b0;
      gin     = 1'b0;
      addsub  = 1'b0;
      gout    = 1'b0;
      dinout  = 1'b0;
      done    = 1'b0;
      busy    = 1'b0;
    end
  end

endmodule

// File: tb/tb_proc_ctrl.sv
// Self-checking bench for proc_ctrl: per-cycle expected output vectors are
// queued as stimulus is driven and compared once the outputs settle.
module tb_proc_ctrl;

  localparam int W = 40;

  logic        clock;
  logic        resetn;
  logic        run;
  logic [15:0] din;
  logic        ir_load;
  logic [15:0] rin;
  logic [15:0] rout;
  logic        ain;
  logic        gin;
  logic        addsub;
  logic        gout;
  logic        dinout;
  logic        done;
  logic        busy;

  logic [W-1:0] exp_q[$];
  int vec_cnt = 0;
  int err_cnt = 0;

  proc_ctrl #(.DW(16), .NREG(16)) dut (
    .clock   (clock),
    .resetn  (resetn),
    .run     (run),
    .din     (din),
    .ir_load (ir_load),
    .rin     (rin),
    .rout    (rout),
    .ain     (ain),
    .gin     (gin),
    .addsub  (addsub),
    .gout    (gout),
    .dinout  (dinout),
    .done    (done),
    .busy    (busy)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    resetn = 1'b0;
    run    = 1'b0;
    din    = '0;
  end

  function automatic logic [15:0] oh(input logic [3:0] f);
    logic [15:0] one;
    one = 16'h0001;
    return one << f;
  endfunction

  // Field order: ir_load, rin, rout, ain, gin, addsub, gout, dinout, done, busy
  function automatic logic [W-1:0] ev(input logic il, input logic [15:0] ri,
                                      input logic [15:0] ro, input logic a,
                                      input logic g, input logic s,
                                      input logic go, input logic di,
                                      input logic dn, input logic bz);
    return {il, ri, ro, a, g, s, go, di, dn, bz};
  endfunction

  function automatic logic [W-1:0] observed();
    return {ir_load, rin, rout, ain, gin, addsub, gout, dinout, done, busy};
  endfunction

  task automatic check_eq(input string tag, input logic [W-1:0] obs,
                          input logic [W-1:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got il=%0b rin=%h rout=%h a=%0b g=%0b s=%0b go=%0b di=%0b dn=%0b bz=%0b, want il=%0b rin=%h rout=%h a=%0b g=%0b s=%0b go=%0b di=%0b dn=%0b bz=%0b",
               tag, obs[39], obs[38:23], obs[22:7], obs[6], obs[5], obs[4],
               obs[3], obs[2], obs[1], obs[0], exp[39], exp[38:23],
               exp[22:7], exp[6], exp[5], exp[4], exp[3], exp[2], exp[1],
               exp[0]);
    end
  endtask

  task automatic compare_next(input string tag);
    logic [W-1:0] e;
    e = exp_q.pop_front();
    check_eq(tag, observed(), e);
  endtask

  // driver: inputs change on the falling edge, outputs sampled 2 ns later
  task automatic drive_cycle(input string tag, input logic rst,
                             input logic r, input logic [15:0] d,
                             input logic [W-1:0] exp);
    @(negedge clock);
    resetn = rst;
    run    = r;
    din    = d;
    exp_q.push_back(exp);
    #2;
    compare_next(tag);
  endtask

  // One instruction from acceptance to done; hold = run level during execute.
  task automatic exec(input string tag, input logic [15:0] instr,
                      input logic [15:0] imm, input logic hold);
    logic [2:0] op;
    logic [3:0] x;
    logic [3:0] y;
    op = instr[10:8];
    x  = instr[7:4];
    y  = instr[3:0];
    drive_cycle({tag, ".load"}, 1'b1, 1'b1, instr,
                ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    case (op)
      3'b000: drive_cycle({tag, ".t1"}, 1'b1, hold, 16'h0000,
                          ev(0, oh(x), oh(y), 0, 0, 0, 0, 0, 1, 1));
      3'b001: drive_cycle({tag, ".t1"}, 1'b1, hold, imm,
                          ev(0, oh(x), 0, 0, 0, 0, 0, 1, 1, 1));
      3'b010, 3'b011: begin
        drive_cycle({tag, ".t1"}, 1'b1, hold, 16'h0000,
                    ev(0, 0, oh(x), 1, 0, 0, 0, 0, 0, 1));
        drive_cycle({tag, ".t2"}, 1'b1, hold, 16'h0000,
                    ev(0, 0, oh(y), 0, 1, op[0], 0, 0, 0, 1));
        drive_cycle({tag, ".t3"}, 1'b1, hold, 16'h0000,
                    ev(0, oh(x), 0, 0, 0, 0, 1, 0, 1, 1));
      end
      default: drive_cycle({tag, ".t1"}, 1'b1, hold, 16'h0000,
                           ev(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    endcase
  endtask

  initial begin
    logic [15:0] instr;
    logic [W-1:0] zero;
    zero = '0;

    // reset holds every output low, even with run asserted
    drive_cycle("reset_run", 1'b0, 1'b1, 16'h0130, zero);
    for (int i = 0; i < 5; i++) begin
      drive_cycle("idle", 1'b1, 1'b0, 16'h0000, zero);
    end

    exec("mvi_r3", 16'h0130, 16'h00AA, 1'b0);
    drive_cycle("after_mvi", 1'b1, 1'b0, 16'h0000, zero);

    exec("mv_r5_r2", 16'h0052, 16'h0000, 1'b0);
    drive_cycle("after_mv", 1'b1, 1'b0, 16'h0000, zero);

    exec("sub_r7_r1", 16'h0371, 16'h0000, 1'b0);
    drive_cycle("after_sub", 1'b1, 1'b0, 16'h0000, zero);

    // back-to-back with run held high through the add
    exec("add_r15_r15", 16'h02FF, 16'h0000, 1'b1);
    exec("mv_r0_r1", 16'h0001, 16'h0000, 1'b0);
    drive_cycle("after_b2b", 1'b1, 1'b0, 16'h0000, zero);

    exec("mv_r9_r9", 16'h0099, 16'h0000, 1'b0);
    exec("mvi_r15", 16'h01F0, 16'hBEEF, 1'b1);

    // reset abort in T2 of an add
    drive_cycle("abort.load", 1'b1, 1'b1, 16'h02AB,
                ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    drive_cycle("abort.t1", 1'b1, 1'b0, 16'h0000,
                ev(0, 0, oh(4'hA), 1, 0, 0, 0, 0, 0, 1));
    drive_cycle("abort.t2", 1'b1, 1'b0, 16'h0000,
                ev(0, 0, oh(4'hB), 0, 1, 0, 0, 0, 0, 1));
    #1;
    resetn = 1'b0;
    exp_q.push_back(zero);
    #1;
    compare_next("abort.async");
    drive_cycle("abort.held", 1'b0, 1'b1, 16'h0000, zero);
    for (int i = 0; i < 3; i++) begin
      drive_cycle("abort.wait", 1'b1, 1'b0, 16'h0000, zero);
    end
    exec("reserved", 16'h07FF, 16'h0000, 1'b0);
    drive_cycle("after_rsv", 1'b1, 1'b0, 16'h0000, zero);

    // random instruction stream with random gaps and run levels
    for (int n = 0; n < 60; n++) begin
      instr = {5'b0, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15))};
      exec("rand", instr, 16'($urandom_range(0, 16'hFFFF)),
           1'($urandom_range(0, 1)));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        drive_cycle("rand_gap", 1'b1, 1'b0, 16'($urandom_range(0, 16'hFFFF)),
                    zero);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/proc_ctrl.md
Name: proc_ctrl

Overview:
- Multi-cycle control unit for the general-purpose processor datapath.
- Latches an instruction from the din bus and sequences it over 1 to 3 execute cycles.
- Drives one-hot register-file enables through 4-to-16 decode of register fields: rin selects the write target, rout selects the bus source.
- Also drives the A/G accumulator enables, the ALU add/sub select and the bus mux selects.

Parameters:
- DW, 16, width of the din bus; the instruction occupies din[10:0].
- NREG, 16, number of registers; one-hot width of rin and rout, fixed to 2^4 by the 4-bit register fields.

Ports:
- clock  input  1  system clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
- run  input  1  start request; sampled only in state T0.
- din  input  DW  instruction/immediate bus; instruction format opcode=din[10:8], rx=din[7:4], ry=din[3:0].
- ir_load  output  1  IR capture strobe, high for the cycle in which the instruction is accepted.
- rin  output  NREG  one-hot register write enable.
- rout  output  NREG  one-hot register bus-drive enable.
- ain  output  1  load A register from the bus.
- gin  output  1  load G register from the ALU.
- addsub  output  1  ALU select: 0 = add, 1 = subtract.
- gout  output  1  G register drives the bus.
- dinout  output  1  din drives the bus.
- done  output  1  single-cycle pulse in the last cycle of an instruction.
- busy  output  1  high in any state other than T0.

Behaviour:
- State register (T0, T1, T2, T3) and 11-bit IR, both async-cleared by resetn=0 to T0 and IR=0.
- All outputs are combinational decodes of state and IR.
- While resetn=0, every output is forced to 0, including ir_load.
- Any output not listed for a state is 0.
- onehot(f) = 16'b1 << f, for f in 0..15.
- T0 (idle):
  - ir_load = run.
  - If run=1: IR <= din[10:0] on the rising edge, next state T1.
  - Otherwise remain in T0.
- T1, opcode 000 (mv rx,ry):
  - rout=onehot(ry), rin=onehot(rx), done=1.
  - Next state T0.
- T1, opcode 001 (mvi rx,#imm):
  - dinout=1, rin=onehot(rx), done=1.
  - The immediate must be presented on din during this cycle.
  - Next state T0.
- T1, opcode 010 (add) or 011 (sub):
  - rout=onehot(rx), ain=1.
  - Next state T2.
- T1, opcode 100 to 111 (reserved):
  - done=1 only; no enables asserted.
  - Next state T0 (executes as a NOP).
- T2:
  - rout=onehot(ry), gin=1, addsub=(opcode==011).
  - Next state T3.
- T3:
  - gout=1, rin=onehot(rx), done=1.
  - Next state T0.
- Latency from ir_load to done:
  - mv, mvi and reserved opcodes: 1 cycle.
  - add and sub: 3 cycles.
- run is ignored outside T0; no queueing.
  - Back-to-back instructions: run held high gives done in cycle N and ir_load in cycle N+1, one idle T0 cycle between instructions.
- rx==ry is legal:
  - mv r,r asserts rin and rout on the same bit.
  - add r,r asserts rout=onehot(r) in both T1 and T2.
- Invariants:
  - rin and rout are each zero or exactly one-hot.
  - Only one of rout, gout and dinout is asserted in any cycle (single bus driver).
- Reset mid-operation:
  - Immediately returns the block to T0 with IR=0.
  - No done is issued for the aborted instruction.
  - On resetn release, the block waits for run.
- busy=1 exactly in states T1, T2 and T3.

Test Plan:
- Reset, then din=0x000 and run=0 for 5 cycles -> busy=0, ir_load=0, all enables 0, no done.
- mvi r3: run=1 with din=0x130; next cycle din=0x00AA -> cycle 1: dinout=1, rin=0x0008, done=1; then busy=0.
- mv r5,r2: din=0x052 -> one cycle with rout=0x0004, rin=0x0020, done=1.
- sub r7,r1: din=0x371 -> T1: rout=0x0080, ain=1; T2: rout=0x0002, gin=1, addsub=1; T3: gout=1, rin=0x0080, done=1.
- add r15,r15 with run held high, followed by mv r0,r1 (din=0x001) -> add completes with done in T3, and ir_load for mv fires the next cycle; mv then gives rout=0x0002, rin=0x0001.
- Reset abort: resetn pulsed low during T2 of an add -> all outputs 0 at once, no done; after release, run=0 keeps the block in T0; a reserved opcode (din=0x7FF) then produces done only, with no enables.
